// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types and constants for the MIPS pipeline front end.
//            - fetchStateT : fetch-stage state encoding
//            - NOP_INSTR   : instruction word used for pipeline bubbles
//            - DEFAULT_RESET_PC : PC loaded on reset unless overridden
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at PCF
        HOLD  = 2'd1,   // fetched word parked in buffer while stalled
        DRAIN = 2'd2    // redirect taken, old request still in flight
    } fetchStateT;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            en              - register may change this cycle (else holds)
//            clr             - with en: insert a bubble (NOP, not valid)
//            load            - with en and no clr: capture a real instruction
//            instrIn/pcPlus4In - instruction word and PC+4 to capture
//            InstrD/PCPlus4D/ValidD - registered decode-stage view
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            load,
    input  logic [31:0]     instrIn,
    input  logic [PC_W-1:0] pcPlus4In,
    output logic [31:0]     InstrD,
    output logic [PC_W-1:0] PCPlus4D,
    output logic            ValidD
);

    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (en) begin
            if (clr) begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else if (load) begin
                InstrD   <= instrIn;
                PCPlus4D <= pcPlus4In;
                ValidD   <= 1'b1;
            end
        end
    end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch front end of the 5-stage MIPS pipeline. Owns
//            PCF and the IF/ID register, fetches over a req/ready handshake
//            and applies decode-resolved branch/jump redirects with a single
//            bubble (no delay slot).
// Ports    : clk, rst              - clock, synchronous active-high reset
//            StallF, StallD        - hazard-unit stalls (OR-ed together)
//            PCSrcD, JumpD         - branch taken / jump, resolved in decode
//            PCBranchD, PCJumpD    - redirect targets (jump wins)
//            imem_req, imem_addr   - fetch request and word address
//            imem_ready, imem_rdata - response strobe and instruction word
//            InstrD, PCPlus4D, ValidD - IF/ID outputs to decode
//            FetchWaitF            - a bubble is being inserted by fetch
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            PCSrcD,
    input  logic            JumpD,
    input  logic [PC_W-1:0] PCBranchD,
    input  logic [PC_W-1:0] PCJumpD,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [PC_W-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchWaitF
);

    fetchStateT      r_state;
    logic [PC_W-1:0] r_pcF;
    logic [PC_W-1:0] r_redirPc;
    logic [31:0]     r_bufInstr;

    logic            w_stall;
    logic            w_redirect;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pcPlus4;
    logic            w_regEn;
    logic            w_regClr;
    logic            w_regLoad;
    logic [31:0]     w_loadInstr;

    // A mismatch between the two stalls is treated conservatively as a stall.
    assign w_stall    = StallF | StallD;
    // Only a real, non-stalled decode instruction may redirect fetch.
    assign w_redirect = (PCSrcD | JumpD) & ValidD & ~StallD;
    assign w_target   = JumpD ? PCJumpD : PCBranchD;
    assign w_pcPlus4  = r_pcF + PC_W'(4);   // wraps modulo 2^PC_W

    assign imem_req   = (r_state == FETCH) | (r_state == DRAIN);
    assign imem_addr  = {r_pcF[PC_W-1:2], 2'b00};
    assign FetchWaitF = ((r_state == FETCH) & ~imem_ready & ~w_stall)
                      | (r_state == DRAIN);

    // IF/ID control. en=0 means the register holds; in DRAIN it keeps the
    // bubble inserted when the redirect was taken.
    always_comb begin
        w_regEn     = 1'b0;
        w_regClr    = 1'b0;
        w_regLoad   = 1'b0;
        w_loadInstr = imem_rdata;
        case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    w_regEn  = 1'b1;
                    w_regClr = 1'b1;
                end else if (w_stall) begin
                    w_regEn  = 1'b0;
                end else if (imem_ready) begin
                    w_regEn   = 1'b1;
                    w_regLoad = 1'b1;
                end else begin
                    w_regEn  = 1'b1;
                    w_regClr = 1'b1;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_regEn  = 1'b1;
                    w_regClr = 1'b1;
                end else if (!w_stall) begin
                    w_regEn     = 1'b1;
                    w_regLoad   = 1'b1;
                    w_loadInstr = r_bufInstr;
                end
            end
            default: begin
                w_regEn = 1'b0;
            end
        endcase
    end

    // PC / state machine. The request address stays fixed until the cycle
    // imem_ready is seen, so a redirect that arrives while a request is
    // pending is parked in r_redirPc until the old response drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pcF      <= RESET_PC;
            r_redirPc  <= '0;
            r_bufInstr <= NOP_INSTR;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect && imem_ready) begin
                        r_pcF <= w_target;
                    end else if (w_redirect) begin
                        r_redirPc <= w_target;
                        r_state   <= DRAIN;
                    end else if (w_stall && imem_ready) begin
                        r_bufInstr <= imem_rdata;
                        r_state    <= HOLD;
                    end else if (!w_stall && imem_ready) begin
                        r_pcF <= w_pcPlus4;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pcF   <= w_target;
                        r_state <= FETCH;
                    end else if (!w_stall) begin
                        r_pcF   <= w_pcPlus4;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        r_pcF   <= r_redirPc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_ifIdReg (
        .clk       (clk),
        .rst       (rst),
        .en        (w_regEn),
        .clr       (w_regClr),
        .load      (w_regLoad),
        .instrIn   (w_loadInstr),
        .pcPlus4In (w_pcPlus4),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A reference model predicts
//            the architectural instruction stream (sequential PCs, redirect
//            targets) into a queue; a monitor pops it whenever decode is
//            presented a fresh valid instruction. Directed sequences cover
//            latency, waits, stalls, redirects, wrap and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, FetchWaitF;
    logic [31:0] garbage;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_W     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .JumpD      (JumpD),
        .PCBranchD  (PCBranchD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchWaitF (FetchWaitF)
    );

    // Instruction memory contents: word i holds 0x2000_0000 + i.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h2000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Non-ready cycles return junk so that a wrongly captured word shows up.
    always_comb imem_rdata = imem_ready ? memWord(imem_addr) : garbage;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] expQ[$];
    logic [31:0] decodePc;
    bit          inDecode = 1'b0;
    bit          fresh    = 1'b0;
    bit          pend     = 1'b0;
    logic [31:0] pendAddr = '0;
    logic        reqS     = 1'b0;
    logic [31:0] addrS    = '0;
    int          nDelivered = 0;

    // Architectural view: each instruction leaving decode is followed by
    // PC+4, or by the redirect target if it branched/jumped while unstalled.
    initial begin : model
        logic mStall, mRedir;
        logic [31:0] mTgt;
        forever begin
            @(posedge clk);
            if (rst) begin
                expQ.delete();
                expQ.push_back(RST_PC);
                inDecode = 1'b0;
                fresh    = 1'b0;
                pend     = 1'b0;
            end else begin
                mStall = StallF | StallD;
                mRedir = (PCSrcD | JumpD) & inDecode & ~StallD;
                mTgt   = JumpD ? PCJumpD : PCBranchD;
                pend     = reqS & ~imem_ready;
                pendAddr = addrS;
                if (mRedir || !mStall) begin
                    if (inDecode)
                        expQ.push_back(mRedir ? mTgt : decodePc + 32'd4);
                    inDecode = 1'b0;
                    fresh    = 1'b1;
                end else begin
                    fresh = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, pendAddr);
            end
            reqS  = imem_req;
            addrS = imem_addr;
            if (ValidD === 1'b0)
                check("bubble_zero", InstrD | PCPlus4D, 32'h0);
            if (ValidD === 1'b1 && fresh) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_instr: got %08h expected none at %0t", InstrD, $time);
                end else begin
                    e = expQ.pop_front();
                    check("sb_instrD", InstrD, memWord(e));
                    check("sb_pcPlus4D", PCPlus4D, e + 32'd4);
                    decodePc = e;
                    inDecode = 1'b1;
                    nDelivered++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic expectIfId(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
        check({tag, "_valid"}, 32'(ValidD), 32'd1);
        check({tag, "_instr"}, InstrD, instr);
        check({tag, "_pc4"}, PCPlus4D, pc4);
    endtask

    initial begin : stim
        logic s;
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        PCBranchD = '0; PCJumpD = '0; imem_ready = 1'b1; garbage = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ValidD), 32'd0);
        check("rst_instr", InstrD, 32'h0);
        check("rst_pc4", PCPlus4D, 32'h0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_req", 32'(imem_req), 32'd1);
        #1 rst = 1'b0;

        // zero-wait streaming
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expectIfId("stream", 32'h2000_0000 + 32'(i), 32'(4 * (i + 1)));
        end

        // two memory wait cycles at PCF=0x10
        #1 imem_ready = 1'b0;
        #1 check("wait_fw", 32'(FetchWaitF), 32'd1);
        check("wait_addr", imem_addr, 32'h10);
        repeat (2) begin
            @(negedge clk);
            check("wait_valid", 32'(ValidD), 32'd0);
            check("wait_fw2", 32'(FetchWaitF), 32'd1);
        end
        #1 imem_ready = 1'b1;
        @(negedge clk);
        expectIfId("after_wait", 32'h2000_0004, 32'h14);
        check("after_wait_addr", imem_addr, 32'h14);

        // 3-cycle stall with data returning -> HOLD
        #1 StallF = 1'b1; StallD = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_req", 32'(imem_req), 32'd0);
            expectIfId("hold", 32'h2000_0004, 32'h14);
        end
        #1 check("hold_fw", 32'(FetchWaitF), 32'd0);
        StallF = 1'b0; StallD = 1'b0;
        @(negedge clk);
        expectIfId("release", 32'h2000_0005, 32'h18);
        check("release_addr", imem_addr, 32'h18);
        @(negedge clk);
        expectIfId("release2", 32'h2000_0006, 32'h1C);

        // taken branch with zero-wait memory
        #1 PCSrcD = 1'b1; PCBranchD = 32'h100;
        @(negedge clk);
        check("br_valid", 32'(ValidD), 32'd0);
        check("br_addr", imem_addr, 32'h100);
        #1 PCSrcD = 1'b0;
        @(negedge clk);
        expectIfId("br_target", 32'h2000_0040, 32'h104);

        // jump while memory is waiting -> DRAIN
        #1 JumpD = 1'b1; PCJumpD = 32'h200; imem_ready = 1'b0;
        @(negedge clk);
        check("drain_valid", 32'(ValidD), 32'd0);
        check("drain_addr", imem_addr, 32'h104);
        check("drain_req", 32'(imem_req), 32'd1);
        check("drain_fw", 32'(FetchWaitF), 32'd1);
        #1 JumpD = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("drain_addr2", imem_addr, 32'h104);
            check("drain_valid2", 32'(ValidD), 32'd0);
        end
        #1 imem_ready = 1'b1;
        @(negedge clk);
        check("drained_addr", imem_addr, 32'h200);
        check("drained_valid", 32'(ValidD), 32'd0);
        @(negedge clk);
        expectIfId("jmp_target", 32'h2000_0080, 32'h204);

        // wrap at the top of the address space
        #1 JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        #1 JumpD = 1'b0;
        @(negedge clk);
        expectIfId("wrap", 32'h5FFF_FFFF, 32'h0);
        check("wrap_pcf", imem_addr, 32'h0);

        // reset while in HOLD
        #1 StallF = 1'b1; StallD = 1'b1;
        @(negedge clk);
        check("pre_rst_req", 32'(imem_req), 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("hold_rst_valid", 32'(ValidD), 32'd0);
        check("hold_rst_addr", imem_addr, RST_PC);
        check("hold_rst_req", 32'(imem_req), 32'd1);
        #1 rst = 1'b0; StallF = 1'b0; StallD = 1'b0;
        @(negedge clk);
        expectIfId("post_rst", 32'h2000_0000, 32'h4);

        // randomized traffic, checked by the scoreboard
        for (int n = 0; n < 4000; n++) begin
            #1;
            garbage    = $urandom;
            rst        = ($urandom_range(0, 599) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            s          = ($urandom_range(0, 5) == 0);
            StallF     = s;
            StallD     = s;
            if ($urandom_range(0, 9) == 0) begin
                StallF = 1'($urandom_range(0, 1));
                StallD = 1'($urandom_range(0, 1));
            end
            PCSrcD    = ($urandom_range(0, 6) == 0);
            JumpD     = ($urandom_range(0, 10) == 0);
            PCBranchD = 32'($urandom_range(0, 1023)) << 2;
            PCJumpD   = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 15) == 0)
                PCBranchD = PCBranchD | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                PCJumpD = 32'hFFFF_FFFC;
            @(negedge clk);
        end

        #1 rst = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        imem_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("delivered_gt_1000", 32'(nDelivered > 1000), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
